pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_if.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 62 ++++++
 tb/tb_pipe_hazard_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: pipeline stage info in, stall/flush/forward controls out
interface pipe_hazard_if;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW, memtoregE, memwriteM, memtoregM, haltW;
  logic        pcsrcM, dmem_ack;
  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushD, flushE, flushM, flushW;
  logic [1:0]  forwardAE, forwardBE;
  logic        halted, mem_err;
  logic [31:0] stall_cnt;
  modport master (
    output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memwriteM, memtoregM, haltW,
           pcsrcM, dmem_ack,
    input  stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW,
           forwardAE, forwardBE, halted, mem_err, stall_cnt
  );
  modport slave (
    input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
           regwriteE, regwriteM, regwriteW, memtoregE, memwriteM, memtoregM, haltW,
           pcsrcM, dmem_ack,
    output stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM, flushW,
           forwardAE, forwardBE, halted, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage hazard unit with forwarding, load-use, memory-wait timeout and halt
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  pipe_hazard_if.slave h
);
  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED, ERROR} state_t;
  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  state_t      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        active, lwstall, memwait, stall_all, flush_br, ld_bubble;
  assign h.forwardAE = (h.regwriteM && h.writeregM != 5'd0 && h.writeregM == h.rsE) ? 2'b10 :
                       (h.regwriteW && h.writeregW != 5'd0 && h.writeregW == h.rsE) ? 2'b01 : 2'b00;
  assign h.forwardBE = (h.regwriteM && h.writeregM != 5'd0 && h.writeregM == h.rtE) ? 2'b10 :
                       (h.regwriteW && h.writeregW != 5'd0 && h.writeregW == h.rtE) ? 2'b01 : 2'b00;
  assign active    = state_q == RUN || state_q == MEMWAIT;
  assign lwstall   = h.memtoregE && h.writeregE != 5'd0 &&
                     (h.writeregE == h.rsD || h.writeregE == h.rtD);
  assign memwait   = (h.memwriteM || h.memtoregM) && !h.dmem_ack;
  // memory wait dominates branch flush, which in turn suppresses the load-use bubble
  assign stall_all = !active || memwait;
  assign flush_br  = active && !memwait && h.pcsrcM;
  assign ld_bubble = active && !memwait && !h.pcsrcM && lwstall;
  assign h.stallF    = stall_all || ld_bubble;
  assign h.stallD    = stall_all || ld_bubble;
  assign h.stallE    = stall_all;
  assign h.stallM    = stall_all;
  assign h.stallW    = stall_all;
  assign h.flushD    = flush_br;
  assign h.flushE    = flush_br || ld_bubble;
  assign h.flushM    = flush_br;
  assign h.flushW    = state_q == ERROR;
  assign h.halted    = state_q == HALTED;
  assign h.mem_err   = state_q == ERROR;
  assign h.stall_cnt = stall_cnt_q;
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    stall_cnt_d = (active && (stall_all || ld_bubble) && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    if (state_q == RUN) begin
      wcnt_d  = '0;
      state_d = memwait ? MEMWAIT : h.haltW ? HALTED : RUN;
    end else if (state_q == MEMWAIT) begin
      wcnt_d  = memwait ? wcnt_q + 8'd1 : wcnt_q;
      state_d = memwait ? ((wcnt_q + 8'd1 == TMO) ? ERROR : MEMWAIT) : h.haltW ? HALTED : RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed checks of forwarding, stalls, timeout, halt and reset
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  pipe_hazard_if d_if();
  pipe_hazard_if t_if();
  pipe_hazard_ctrl u_dut (.clk(clk), .reset(reset), .h(d_if.slave));
  pipe_hazard_ctrl #(.MEM_TIMEOUT(3)) u_tmo (.clk(clk), .reset(reset), .h(t_if.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  initial begin
    {d_if.rsD, d_if.rtD, d_if.rsE, d_if.rtE, d_if.writeregE, d_if.writeregM, d_if.writeregW} = '0;
    {d_if.regwriteE, d_if.regwriteM, d_if.regwriteW, d_if.memtoregE, d_if.memwriteM,
     d_if.memtoregM, d_if.haltW, d_if.pcsrcM, d_if.dmem_ack} = '0;
    {t_if.rsD, t_if.rtD, t_if.rsE, t_if.rtE, t_if.writeregE, t_if.writeregM, t_if.writeregW} = '0;
    {t_if.regwriteE, t_if.regwriteM, t_if.regwriteW, t_if.memtoregE, t_if.memwriteM,
     t_if.memtoregM, t_if.haltW, t_if.pcsrcM, t_if.dmem_ack} = '0;
    #2;
    chk("rst_halted", 32'(d_if.halted), 32'd0);
    chk("rst_memerr", 32'(d_if.mem_err), 32'd0);
    chk("rst_cnt", d_if.stall_cnt, 32'd0);
    chk("rst_stallF", 32'(d_if.stallF), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    // forwarding: M beats W, writereg 0 never forwards
    d_if.regwriteM = 1; d_if.writeregM = 5; d_if.regwriteW = 1; d_if.writeregW = 5;
    d_if.rsE = 5; d_if.rtE = 0;
    #1;
    chk("fwdA_M", 32'(d_if.forwardAE), 32'd2);
    chk("fwdB_none", 32'(d_if.forwardBE), 32'd0);
    d_if.writeregM = 0; d_if.rtE = 5;
    #1;
    chk("fwdA_W", 32'(d_if.forwardAE), 32'd1);
    chk("fwdB_W", 32'(d_if.forwardBE), 32'd1);
    d_if.regwriteW = 0;
    #1;
    chk("fwdA_off", 32'(d_if.forwardAE), 32'd0);
    d_if.regwriteM = 0; d_if.rsE = 0; d_if.rtE = 0; d_if.writeregW = 0;
    // load-use with writeregE = 0 must not stall
    @(negedge clk);
    d_if.memtoregE = 1; d_if.writeregE = 0; d_if.rsD = 0;
    #1;
    chk("lw_r0_stallF", 32'(d_if.stallF), 32'd0);
    d_if.writeregE = 3; d_if.rtD = 3; d_if.rsD = 1;
    #1;
    chk("lw_stallF", 32'(d_if.stallF), 32'd1);
    chk("lw_stallD", 32'(d_if.stallD), 32'd1);
    chk("lw_flushE", 32'(d_if.flushE), 32'd1);
    chk("lw_stallE", 32'(d_if.stallE), 32'd0);
    chk("lw_flushD", 32'(d_if.flushD), 32'd0);
    @(negedge clk);
    #1;
    chk("lw_cnt", d_if.stall_cnt, 32'd1);
    d_if.pcsrcM = 1;
    #1;
    chk("br_flush", {29'd0, d_if.flushD, d_if.flushE, d_if.flushM}, 32'd7);
    chk("br_stalls", {27'd0, d_if.stallF, d_if.stallD, d_if.stallE, d_if.stallM, d_if.stallW}, 32'd0);
    @(negedge clk);
    #1;
    chk("br_cnt", d_if.stall_cnt, 32'd1);
    d_if.pcsrcM = 0; d_if.memtoregE = 0; d_if.writeregE = 0; d_if.rtD = 0; d_if.rsD = 0;
    // memory wait: four unacked cycles then ack
    d_if.memtoregM = 1; d_if.dmem_ack = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mw_stalls%0d", i),
          {27'd0, d_if.stallF, d_if.stallD, d_if.stallE, d_if.stallM, d_if.stallW}, 32'd31);
      chk($sformatf("mw_flush%0d", i), {28'd0, d_if.flushD, d_if.flushE, d_if.flushM, d_if.flushW}, 32'd0);
      @(negedge clk);
    end
    d_if.dmem_ack = 1;
    #1;
    chk("mw_ack_stalls", {27'd0, d_if.stallF, d_if.stallD, d_if.stallE, d_if.stallM, d_if.stallW}, 32'd0);
    @(negedge clk);
    d_if.memtoregM = 0; d_if.dmem_ack = 0;
    #1;
    chk("mw_cnt", d_if.stall_cnt, 32'd5);
    chk("mw_run_stallF", 32'(d_if.stallF), 32'd0);
    // halt beats a simultaneous taken branch
    d_if.haltW = 1; d_if.pcsrcM = 1;
    #1;
    chk("hlt_pre_halted", 32'(d_if.halted), 32'd0);
    @(negedge clk);
    #1;
    chk("hlt_halted", 32'(d_if.halted), 32'd1);
    chk("hlt_stalls", {27'd0, d_if.stallF, d_if.stallD, d_if.stallE, d_if.stallM, d_if.stallW}, 32'd31);
    chk("hlt_flush", {28'd0, d_if.flushD, d_if.flushE, d_if.flushM, d_if.flushW}, 32'd0);
    d_if.haltW = 0; d_if.pcsrcM = 0;
    d_if.regwriteM = 1; d_if.writeregM = 7; d_if.rsE = 7;
    #1;
    chk("hlt_fwd", 32'(d_if.forwardAE), 32'd2);
    repeat (10) @(negedge clk);
    #1;
    chk("hlt_sticky", 32'(d_if.halted), 32'd1);
    chk("hlt_cnt", d_if.stall_cnt, 32'd5);
    d_if.regwriteM = 0; d_if.writeregM = 0; d_if.rsE = 0;
    // timeout on the MEM_TIMEOUT=3 instance
    t_if.memtoregM = 1; t_if.dmem_ack = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("tmo_pre_err", 32'(t_if.mem_err), 32'd0);
    @(negedge clk);
    #1;
    chk("tmo_err", 32'(t_if.mem_err), 32'd1);
    chk("tmo_flushW", 32'(t_if.flushW), 32'd1);
    chk("tmo_stallF", 32'(t_if.stallF), 32'd1);
    chk("tmo_cnt", t_if.stall_cnt, 32'd4);
    t_if.memtoregM = 0;
    @(negedge clk);
    #1;
    chk("tmo_sticky", 32'(t_if.mem_err), 32'd1);
    chk("tmo_cnt_hold", t_if.stall_cnt, 32'd4);
    // asynchronous reset clears ERROR and HALTED without waiting for an edge
    #1 reset = 1'b1;
    #1;
    chk("ar_memerr", 32'(t_if.mem_err), 32'd0);
    chk("ar_t_cnt", t_if.stall_cnt, 32'd0);
    chk("ar_halted", 32'(d_if.halted), 32'd0);
    chk("ar_d_cnt", d_if.stall_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_t_stallF", 32'(t_if.stallF), 32'd0);
    chk("post_d_stallW", 32'(d_if.stallW), 32'd0);
    chk("post_t_flushW", 32'(t_if.flushW), 32'd0);
    chk("post_t_cnt", t_if.stall_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
